// File: rtl/zap_instr_wb_fetcher.sv
// Purpose: instruction-side Wishbone classic read master with a small entry FIFO feeding fetch.
// Latency: ack at edge n makes the word visible (o_valid) from edge n; next request issues at n+1.
// Backpressure: i_stall holds the head entry; requests stop while the FIFO is full or after a bus error.
module zap_instr_wb_fetcher #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'd0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic [31:0] o_instruction,
   output logic        o_valid,
   output logic        o_instr_abort,
   output logic [31:0] o_pc,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_ack,
   input  logic        i_wb_err
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam int          CW       = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [31:0] ALIGN    = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, SLEEP} state_t;

   state_t        state;
   logic [31:0]   pc_ff;

   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic          fifo_abort [FIFO_DEPTH];
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          bus_done;
   logic          push;
   logic          pop;

   // A response only lands in the FIFO when it belongs to a live request; a
   // redirect on the same edge turns it into a discard.
   assign bus_done = i_wb_ack | i_wb_err;
   assign push     = (state == REQ) && bus_done && !i_redirect;
   assign pop      = o_valid && !i_stall && !i_redirect;

   assign o_valid       = (count != '0);
   assign o_instruction = fifo_instr[rd_ptr];
   assign o_instr_abort = fifo_abort[rd_ptr];
   assign o_pc          = fifo_pc[rd_ptr];

   assign o_wb_stb = o_wb_cyc;
   assign o_wb_we  = 1'b0;
   assign o_wb_sel = 4'hF;

   // Bus FSM: one outstanding read at a time, redirect overrides everything.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= IDLE;
         pc_ff    <= RESET_PC & ALIGN;
         o_wb_cyc <= 1'b0;
         o_wb_adr <= 32'd0;
      end else if (i_redirect) begin
         pc_ff <= i_redirect_pc & ALIGN;
         case (state)
            REQ, DRAIN: begin
               // A cycle still on the bus must complete before a new one starts.
               if (bus_done) begin
                  state    <= IDLE;
                  o_wb_cyc <= 1'b0;
               end else begin
                  state    <= DRAIN;
               end
            end
            default: begin
               state    <= IDLE;
               o_wb_cyc <= 1'b0;
            end
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (count < FULL_CNT) begin
                  o_wb_cyc <= 1'b1;
                  o_wb_adr <= pc_ff;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (i_wb_ack) begin
                  o_wb_cyc <= 1'b0;
                  pc_ff    <= pc_ff + 32'd4;
                  state    <= IDLE;
               end else if (i_wb_err) begin
                  // Stop fetching; only a redirect wakes us up again.
                  o_wb_cyc <= 1'b0;
                  state    <= SLEEP;
               end
            end
            DRAIN: begin
               if (bus_done) begin
                  o_wb_cyc <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= SLEEP;
            end
         endcase
      end
   end

   // Entry FIFO: storage written on push, pointers/count flushed on redirect.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr[i] <= 32'd0;
            fifo_abort[i] <= 1'b0;
            fifo_pc[i]    <= 32'd0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (i_redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_instr[wr_ptr] <= i_wb_err ? 32'd0 : i_wb_dat;
            fifo_abort[wr_ptr] <= i_wb_err;
            fifo_pc[wr_ptr]    <= o_wb_adr;
            wr_ptr             <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_zap_instr_wb_fetcher.sv
// Directed bench for zap_instr_wb_fetcher: streaming, stall/full, bus error,
// redirect during an outstanding cycle, redirect coincident with ack, and PC wrap.
module tb_zap_instr_wb_fetcher;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'd0;
   logic        i_stall = 1'b0;
   logic [31:0] o_instruction;
   logic        o_valid;
   logic        o_instr_abort;
   logic [31:0] o_pc;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [3:0]  o_wb_sel;
   logic [31:0] o_wb_adr;
   logic [31:0] i_wb_dat;
   logic        i_wb_ack;
   logic        i_wb_err;

   // Memory model controls
   logic        auto_ack = 1'b0;
   logic        err_en   = 1'b0;
   logic [31:0] err_adr  = 32'd0;
   logic        man_ack  = 1'b0;
   logic [31:0] man_dat  = 32'd0;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Zero-wait memory returning data = address, with one optional error address.
   assign i_wb_err = auto_ack && o_wb_cyc && err_en && (o_wb_adr == err_adr);
   assign i_wb_ack = (auto_ack && o_wb_cyc && !(err_en && (o_wb_adr == err_adr))) || man_ack;
   assign i_wb_dat = man_ack ? man_dat : o_wb_adr;

   always #5 i_clk = ~i_clk;

   zap_instr_wb_fetcher #(.FIFO_DEPTH(4), .RESET_PC(32'd0)) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_stall       (i_stall),
      .o_instruction (o_instruction),
      .o_valid       (o_valid),
      .o_instr_abort (o_instr_abort),
      .o_pc          (o_pc),
      .o_wb_cyc      (o_wb_cyc),
      .o_wb_stb      (o_wb_stb),
      .o_wb_we       (o_wb_we),
      .o_wb_sel      (o_wb_sel),
      .o_wb_adr      (o_wb_adr),
      .i_wb_dat      (i_wb_dat),
      .i_wb_ack      (i_wb_ack),
      .i_wb_err      (i_wb_err)
   );

   task automatic do_reset(input logic redir, input logic [31:0] rpc);
      i_reset_n     = 1'b0;
      i_redirect    = redir;
      i_redirect_pc = rpc;
      man_ack       = 1'b0;
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      auto_ack = 1'b0;
      i_stall  = 1'b0;
      i_reset_n = 1'b0;
      @(negedge i_clk);
      total_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL reset_cyc got %0b want 0", o_wb_cyc); else pass_cnt++;
      total_cnt++; if (o_wb_stb !== 1'b0) $display("FAIL reset_stb got %0b want 0", o_wb_stb); else pass_cnt++;
      total_cnt++; if (o_wb_adr !== 32'd0) $display("FAIL reset_adr got %h want 0", o_wb_adr); else pass_cnt++;
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", o_valid); else pass_cnt++;
      total_cnt++; if (o_instr_abort !== 1'b0) $display("FAIL reset_abort got %0b want 0", o_instr_abort); else pass_cnt++;
      total_cnt++; if (o_instruction !== 32'd0) $display("FAIL reset_instr got %h want 0", o_instruction); else pass_cnt++;
      total_cnt++; if (o_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", o_pc); else pass_cnt++;
      total_cnt++; if (o_wb_sel !== 4'hF) $display("FAIL wb_sel got %h want F", o_wb_sel); else pass_cnt++;
      total_cnt++; if (o_wb_we !== 1'b0) $display("FAIL wb_we got %0b want 0", o_wb_we); else pass_cnt++;
      i_reset_n = 1'b1;
      @(negedge i_clk);
      total_cnt++; if (o_wb_cyc !== 1'b1) $display("FAIL first_req_cyc got %0b want 1", o_wb_cyc); else pass_cnt++;
      total_cnt++; if (o_wb_stb !== 1'b1) $display("FAIL first_req_stb got %0b want 1", o_wb_stb); else pass_cnt++;
      total_cnt++; if (o_wb_adr !== 32'd0) $display("FAIL first_req_adr got %h want 0", o_wb_adr); else pass_cnt++;
      #2 i_reset_n = 1'b0;
      #1;
      total_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL async_reset_cyc got %0b want 0", o_wb_cyc); else pass_cnt++;
      @(negedge i_clk);
   endtask

   task automatic test_stream();
      logic [31:0] seen_pc  [4];
      logic [31:0] seen_ins [4];
      int          seen_cyc [4];
      int          n = 0;
      auto_ack = 1'b1;
      err_en   = 1'b0;
      i_stall  = 1'b0;
      do_reset(1'b0, 32'd0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge i_clk);
         if (o_valid && n < 4) begin
            seen_pc[n]  = o_pc;
            seen_ins[n] = o_instruction;
            seen_cyc[n] = i;
            n++;
         end
      end
      total_cnt++; if (n !== 4) $display("FAIL stream_count got %0d want 4", n); else pass_cnt++;
      if (n == 4) begin
         total_cnt++; if (seen_cyc[0] !== 2) $display("FAIL stream_first_cycle got %0d want 2", seen_cyc[0]); else pass_cnt++;
         for (int k = 0; k < 4; k++) begin
            total_cnt++; if (seen_pc[k] !== 32'(4 * k)) $display("FAIL stream_pc[%0d] got %h want %h", k, seen_pc[k], 32'(4 * k)); else pass_cnt++;
            total_cnt++; if (seen_ins[k] !== 32'(4 * k)) $display("FAIL stream_instr[%0d] got %h want %h", k, seen_ins[k], 32'(4 * k)); else pass_cnt++;
            if (k > 0) begin
               total_cnt++; if (seen_cyc[k] - seen_cyc[k-1] !== 2) $display("FAIL stream_spacing[%0d] got %0d want 2", k, seen_cyc[k] - seen_cyc[k-1]); else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_stall();
      int          rises = 0;
      logic        prev  = 1'b0;
      logic [31:0] seen_pc [5];
      int          n = 0;
      auto_ack = 1'b1;
      err_en   = 1'b0;
      i_stall  = 1'b1;
      do_reset(1'b0, 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         if (o_wb_cyc && !prev) rises++;
         prev = o_wb_cyc;
      end
      total_cnt++; if (rises !== 4) $display("FAIL stall_bus_cycles got %0d want 4", rises); else pass_cnt++;
      total_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL stall_cyc_idle got %0b want 0", o_wb_cyc); else pass_cnt++;
      total_cnt++; if (o_valid !== 1'b1) $display("FAIL stall_valid got %0b want 1", o_valid); else pass_cnt++;
      total_cnt++; if (o_pc !== 32'd0) $display("FAIL stall_head_pc got %h want 0", o_pc); else pass_cnt++;
      i_stall = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (o_valid && n < 5) begin
            seen_pc[n] = o_pc;
            n++;
         end
         @(negedge i_clk);
      end
      total_cnt++; if (n !== 5) $display("FAIL drain_count got %0d want 5", n); else pass_cnt++;
      for (int k = 0; k < n; k++) begin
         total_cnt++; if (seen_pc[k] !== 32'(4 * k)) $display("FAIL drain_pc[%0d] got %h want %h", k, seen_pc[k], 32'(4 * k)); else pass_cnt++;
      end
   endtask

   task automatic test_error();
      logic found = 1'b0;
      int   cyc_seen = 0;
      auto_ack = 1'b1;
      err_en   = 1'b1;
      err_adr  = 32'h20;
      i_stall  = 1'b0;
      do_reset(1'b0, 32'd0);
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge i_clk);
         if (o_valid && o_instr_abort) found = 1'b1;
      end
      total_cnt++; if (found !== 1'b1) $display("FAIL abort_seen got %0b want 1", found); else pass_cnt++;
      total_cnt++; if (o_instruction !== 32'd0) $display("FAIL abort_instr got %h want 0", o_instruction); else pass_cnt++;
      total_cnt++; if (o_pc !== 32'h20) $display("FAIL abort_pc got %h want 20", o_pc); else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         if (o_wb_cyc) cyc_seen++;
      end
      total_cnt++; if (cyc_seen !== 0) $display("FAIL sleep_cyc got %0d want 0", cyc_seen); else pass_cnt++;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h102;
      @(negedge i_clk);
      i_redirect = 1'b0;
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL wake_valid got %0b want 0", o_valid); else pass_cnt++;
      @(negedge i_clk);
      total_cnt++; if (o_wb_cyc !== 1'b1) $display("FAIL wake_cyc got %0b want 1", o_wb_cyc); else pass_cnt++;
      total_cnt++; if (o_wb_adr !== 32'h100) $display("FAIL wake_adr got %h want 100", o_wb_adr); else pass_cnt++;
      @(negedge i_clk);
      total_cnt++; if (o_valid !== 1'b1) $display("FAIL wake_entry_valid got %0b want 1", o_valid); else pass_cnt++;
      total_cnt++; if (o_instr_abort !== 1'b0) $display("FAIL wake_abort got %0b want 0", o_instr_abort); else pass_cnt++;
      total_cnt++; if (o_pc !== 32'h100) $display("FAIL wake_pc got %h want 100", o_pc); else pass_cnt++;
      err_en = 1'b0;
   endtask

   task automatic test_redirect_drain();
      auto_ack = 1'b0;
      err_en   = 1'b0;
      i_stall  = 1'b0;
      do_reset(1'b1, 32'h10);
      @(negedge i_clk);
      i_redirect = 1'b0;
      total_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL drain_pre_cyc got %0b want 0", o_wb_cyc); else pass_cnt++;
      @(negedge i_clk);
      total_cnt++; if (o_wb_adr !== 32'h10) $display("FAIL drain_req_adr got %h want 10", o_wb_adr); else pass_cnt++;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h40;
      @(negedge i_clk);
      i_redirect = 1'b0;
      total_cnt++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h10) $display("FAIL drain_hold got cyc=%0b adr=%h want cyc=1 adr=10", o_wb_cyc, o_wb_adr); else pass_cnt++;
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL drain_valid got %0b want 0", o_valid); else pass_cnt++;
      repeat (2) @(negedge i_clk);
      total_cnt++; if (o_wb_cyc !== 1'b1) $display("FAIL drain_hold_late got %0b want 1", o_wb_cyc); else pass_cnt++;
      man_dat = 32'hDEAD_BEEF;
      man_ack = 1'b1;
      @(negedge i_clk);
      man_ack = 1'b0;
      total_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL drain_done_cyc got %0b want 0", o_wb_cyc); else pass_cnt++;
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL stale_discard got valid=%0b instr=%h want valid=0", o_valid, o_instruction); else pass_cnt++;
      @(negedge i_clk);
      total_cnt++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h40) $display("FAIL post_drain_req got cyc=%0b adr=%h want cyc=1 adr=40", o_wb_cyc, o_wb_adr); else pass_cnt++;
      man_dat = 32'h1234_5678;
      man_ack = 1'b1;
      @(negedge i_clk);
      man_ack = 1'b0;
      total_cnt++; if (o_valid !== 1'b1) $display("FAIL post_drain_valid got %0b want 1", o_valid); else pass_cnt++;
      total_cnt++; if (o_instruction !== 32'h1234_5678) $display("FAIL post_drain_instr got %h want 12345678", o_instruction); else pass_cnt++;
      total_cnt++; if (o_pc !== 32'h40) $display("FAIL post_drain_pc got %h want 40", o_pc); else pass_cnt++;
   endtask

   task automatic test_redirect_same_edge();
      // Continues from test_redirect_drain: 0x40 entry pops, 0x44 is requested.
      @(negedge i_clk);
      total_cnt++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h44) $display("FAIL same_pre_req got cyc=%0b adr=%h want cyc=1 adr=44", o_wb_cyc, o_wb_adr); else pass_cnt++;
      man_dat       = 32'hBAD0_BAD0;
      man_ack       = 1'b1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h80;
      @(negedge i_clk);
      man_ack    = 1'b0;
      i_redirect = 1'b0;
      total_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL same_cyc got %0b want 0", o_wb_cyc); else pass_cnt++;
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL same_valid got %0b want 0", o_valid); else pass_cnt++;
      @(negedge i_clk);
      total_cnt++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h80) $display("FAIL same_next_req got cyc=%0b adr=%h want cyc=1 adr=80", o_wb_cyc, o_wb_adr); else pass_cnt++;
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL same_still_empty got %0b want 0", o_valid); else pass_cnt++;
      man_dat = 32'hCAFE_0080;
      man_ack = 1'b1;
      @(negedge i_clk);
      man_ack = 1'b0;
      total_cnt++; if (o_valid !== 1'b1 || o_instruction !== 32'hCAFE_0080 || o_pc !== 32'h80) $display("FAIL same_entry got valid=%0b instr=%h pc=%h want 1 cafe0080 80", o_valid, o_instruction, o_pc); else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [31:0] seen_pc  [2];
      logic [31:0] seen_ins [2];
      int          n = 0;
      auto_ack = 1'b1;
      err_en   = 1'b0;
      i_stall  = 1'b0;
      do_reset(1'b1, 32'hFFFF_FFFC);
      @(negedge i_clk);
      i_redirect = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         if (o_valid && n < 2) begin
            seen_pc[n]  = o_pc;
            seen_ins[n] = o_instruction;
            n++;
         end
      end
      total_cnt++; if (n !== 2) $display("FAIL wrap_count got %0d want 2", n); else pass_cnt++;
      if (n == 2) begin
         total_cnt++; if (seen_pc[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got %h want fffffffc", seen_pc[0]); else pass_cnt++;
         total_cnt++; if (seen_pc[1] !== 32'h0) $display("FAIL wrap_pc1 got %h want 0", seen_pc[1]); else pass_cnt++;
         total_cnt++; if (seen_ins[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_instr0 got %h want fffffffc", seen_ins[0]); else pass_cnt++;
         total_cnt++; if (seen_ins[1] !== 32'h0) $display("FAIL wrap_instr1 got %h want 0", seen_ins[1]); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_error();
      test_redirect_drain();
      test_redirect_same_edge();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
